// File: rtl/pipe_cpu_pkg.sv
// Shared pipeline definitions: datapath width, PC step, NOP encoding and
// the fetch-queue entry layout.
package pipe_cpu_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned FQ_DEPTH = 2;

   localparam logic [XLEN-1:0] PC_INC    = 32'd4;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

   // One fetched instruction together with the address of the next one.
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue between instruction memory and the IF/ID boundary.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   push_i, data_i  write data_i at the tail (ignored when full without a pop)
//   pop_i           drop the head entry (ignored when empty)
//   flush_i         discard all entries; wins over push and pop
//   count_o         number of valid entries (0..2)
//   head_o          oldest entry; contents are stale when count_o == 0
module fetch_queue
   import pipe_cpu_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  fetch_entry_t data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   fetch_entry_t mem_q [FQ_DEPTH];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;
   logic         pop_ok;
   logic         push_ok;

   // A pop in the same cycle frees the slot, so a full queue still accepts a push.
   assign pop_ok  = pop_i && (count_q != 2'd0);
   assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

   // Pointer and occupancy tracking.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr_q <= ~wr_ptr_q;
         if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_ok) - 2'(pop_ok);
      end
   end

   // Entry storage; contents are only observed while counted as valid.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding-request memory
// interface and a two-entry buffer feeding the IF/ID boundary.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   imem_req_o, imem_addr_o      fetch request / word-aligned address
//   imem_rdata_i                 instruction word, one cycle after request
//   redirect_i, redirect_pc_i    taken branch/jump: flush and refetch
//   id_valid_o, id_instr_o,      presented instruction and its address + 4
//   id_pc4_o
//   id_ready_i                   ID accepts the presented instruction
module fetch_unit
   import pipe_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic [XLEN-1:0] imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            id_valid_o,
   output logic [XLEN-1:0] id_instr_o,
   output logic [XLEN-1:0] id_pc4_o,
   input  logic            id_ready_i
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic            inflight_q;
   logic            kill_q;
   fetch_entry_t    last_q;

   logic [1:0]      q_count;
   fetch_entry_t    q_head;
   fetch_entry_t    q_push_data;
   logic            q_push;
   logic            pop;
   logic [2:0]      occupancy;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc_i[1:0];

   assign id_valid_o = (q_count != 2'd0);
   assign pop        = id_valid_o && id_ready_i;

   // Slots committed after this edge: queued + outstanding - leaving.
   assign occupancy  = 3'(q_count) + 3'(inflight_q) - 3'(pop);
   assign imem_req_o = !rst_i && !redirect_i && (occupancy < 3'(FQ_DEPTH));
   assign imem_addr_o = pc_q;

   // A response from the old path is dropped in the redirect cycle itself;
   // kill_q guards the following cycle as well.
   assign q_push            = inflight_q && !kill_q && !redirect_i;
   assign q_push_data.instr = imem_rdata_i;
   assign q_push_data.pc4   = req_pc_q + PC_INC;

   fetch_queue u_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (q_push),
      .data_i  (q_push_data),
      .pop_i   (pop),
      .flush_i (redirect_i),
      .count_o (q_count),
      .head_o  (q_head)
   );

   // Outputs hold the last presented entry while the queue is empty.
   assign id_instr_o = id_valid_o ? q_head.instr : last_q.instr;
   assign id_pc4_o   = id_valid_o ? q_head.pc4   : last_q.pc4;

   // PC, outstanding-request tracking and last-presented capture.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= RESET_PC;
         inflight_q <= 1'b0;
         kill_q     <= 1'b0;
         last_q     <= '{instr: NOP_INSTR, pc4: '0};
      end else begin
         inflight_q <= imem_req_o;
         kill_q     <= redirect_i;
         if (redirect_i) begin
            pc_q <= {redirect_pc_i[XLEN-1:2], 2'b00};
         end else if (imem_req_o) begin
            pc_q <= pc_q + PC_INC;
         end
         if (imem_req_o) req_pc_q <= pc_q;
         if (id_valid_o) last_q <= q_head;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory word at address A is A>>2, expected
// presented pc4 values are queued by the stimulus and checked by a monitor.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        id_valid_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc4_o;
   logic        id_ready_i = 1'b1;

   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_valid_o    (id_valid_o),
      .id_instr_o    (id_instr_o),
      .id_pc4_o      (id_pc4_o),
      .id_ready_i    (id_ready_i)
   );

   // Instruction memory: word[i] = i, returned one cycle after the request.
   always @(posedge clk) begin
      imem_rdata_i <= imem_req_o ? (imem_addr_o >> 2) : 32'hDEAD_BEEF;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Monitor: every transfer must match the next expected pc4 / instr.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst_i && !redirect_i && id_valid_o && id_ready_i) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_transfer actual pc4=%h instr=%h required none",
                        id_pc4_o, id_instr_o);
            end else begin
               e = exp_q.pop_front();
               check("xfer_pc4", id_pc4_o, e);
               check("xfer_instr", id_instr_o, (e - 32'd4) >> 2);
            end
         end
      end
   end

   // Stimulus: one iteration per cycle, inputs driven after the edge.
   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req", 32'(imem_req_o), 32'd0);
      check("rst_valid", 32'(id_valid_o), 32'd0);
      check("rst_instr", id_instr_o, 32'd0);
      check("rst_pc4", id_pc4_o, 32'd0);
      check("rst_addr", imem_addr_o, 32'd0);

      for (int t = 0; t <= 32; t++) begin
         @(posedge clk);
         #1;
         rst_i         = (t == 25);
         redirect_i    = (t == 11) || (t == 16) || (t == 17);
         redirect_pc_i = (t == 11) ? 32'h0000_0103 :
                         (t == 16) ? 32'h0000_0200 :
                         (t == 17) ? 32'hFFFF_FFFC : 32'h0;
         id_ready_i    = !((t >= 3 && t <= 7) || (t >= 23 && t <= 25) || t >= 31);
         case (t)
            0:  begin exp_q.push_back(32'd4); exp_q.push_back(32'd8);
                      exp_q.push_back(32'd12); exp_q.push_back(32'd16); end
            11: begin exp_q.push_back(32'h104); exp_q.push_back(32'h108); end
            17: begin exp_q.push_back(32'h0); exp_q.push_back(32'h4);
                      exp_q.push_back(32'h8); end
            26: begin exp_q.push_back(32'd4); exp_q.push_back(32'd8);
                      exp_q.push_back(32'd12); end
            default: ;
         endcase

         @(negedge clk);
         case (t)
            0:  begin check("t0_req", 32'(imem_req_o), 32'd1);
                      check("t0_addr", imem_addr_o, 32'd0);
                      check("t0_valid", 32'(id_valid_o), 32'd0); end
            1:  begin check("t1_req", 32'(imem_req_o), 32'd1);
                      check("t1_addr", imem_addr_o, 32'd4); end
            2:  begin check("t2_valid", 32'(id_valid_o), 32'd1);
                      check("t2_addr", imem_addr_o, 32'd8); end
            5:  begin check("stall_req", 32'(imem_req_o), 32'd0);
                      check("stall_valid", 32'(id_valid_o), 32'd1);
                      check("stall_pc4", id_pc4_o, 32'd8);
                      check("stall_addr", imem_addr_o, 32'd12); end
            11: check("redir_req", 32'(imem_req_o), 32'd0);
            12: begin check("redir_fetch_req", 32'(imem_req_o), 32'd1);
                      check("redir_fetch_addr", imem_addr_o, 32'h100);
                      check("redir_flush_valid", 32'(id_valid_o), 32'd0); end
            13: check("redir_t13_valid", 32'(id_valid_o), 32'd0);
            14: begin check("redir_first_valid", 32'(id_valid_o), 32'd1);
                      check("redir_first_pc4", id_pc4_o, 32'h104); end
            16: check("b2b_req0", 32'(imem_req_o), 32'd0);
            17: check("b2b_req1", 32'(imem_req_o), 32'd0);
            18: begin check("wrap_req0", 32'(imem_req_o), 32'd1);
                      check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
                      check("wrap_valid", 32'(id_valid_o), 32'd0); end
            19: begin check("wrap_req1", 32'(imem_req_o), 32'd1);
                      check("wrap_addr1", imem_addr_o, 32'h0); end
            24: begin check("full_valid", 32'(id_valid_o), 32'd1);
                      check("full_req", 32'(imem_req_o), 32'd0);
                      check("full_pc4", id_pc4_o, 32'd12); end
            25: check("pulse_req", 32'(imem_req_o), 32'd0);
            26: begin check("post_rst_valid", 32'(id_valid_o), 32'd0);
                      check("post_rst_pc4", id_pc4_o, 32'd0);
                      check("post_rst_instr", id_instr_o, 32'd0);
                      check("post_rst_req", 32'(imem_req_o), 32'd1);
                      check("post_rst_addr", imem_addr_o, 32'd0); end
            default: ;
         endcase
      end

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 imem_req_o  output  1  fetch request to instruction memory.
REQ-005 imem_addr_o  output  32  fetch address, word aligned.
REQ-006 imem_rdata_i  input  32  instruction word, valid exactly one cycle after its request.
REQ-007 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-008 redirect_pc_i  input  32  new fetch address; bits [1:0] are ignored.
REQ-009 id_valid_o  output  1  instruction presented to the IF/ID boundary.
REQ-010 id_instr_o  output  32  presented instruction.
REQ-011 id_pc4_o  output  32  address of the presented instruction plus 4.
REQ-012 id_ready_i  input  1  ID can accept; low means the hazard unit has stalled ID.

Function
REQ-013 Instruction memory SHALL always accept requests; each request SHALL return its data on imem_rdata_i in the next cycle.
REQ-014 The unit SHALL keep a fetch PC register and a 2-entry in-order queue; each entry holds {instr, pc4}.
REQ-015 Transfer SHALL occur in a cycle with id_valid_o=1 and id_ready_i=1; the head entry is popped at that edge.
REQ-016 id_valid_o SHALL equal "queue not empty"; id_instr_o and id_pc4_o SHALL show the head entry, or hold their last values when the queue is empty.
REQ-017 imem_req_o SHALL be 1 when rst_i=0, redirect_i=0, and (count + inflight - pop) < 2; inflight is a 1-bit flag for an outstanding request, and pop is the transfer bit this cycle.
REQ-018 imem_addr_o SHALL equal the PC; on a request, the PC SHALL advance by 4, modulo 2^32.
REQ-019 A returning response SHALL be written at the queue tail with pc4 = its request address + 4, unless it has been killed.
REQ-020 The queue SHALL support push and pop in the same cycle at any occupancy, including full; it SHALL never overflow.
REQ-021 Minimum latency: request in cycle N, data captured at the end of N+1, id_valid_o=1 in N+2.
REQ-022 Redirect cycle behaviour when redirect_i=1:
- the queue SHALL be flushed, including any head being transferred that cycle (redirect has priority);
- any in-flight response arriving next cycle SHALL be discarded;
- PC SHALL load {redirect_pc_i[31:2],2'b00};
- no request SHALL be issued that cycle.
REQ-023 The first request after a redirect SHALL be issued the following cycle at the new PC.
REQ-024 Back-to-back redirects: the last redirect_pc_i SHALL win; no instruction from an earlier path SHALL ever be presented.
REQ-025 Under continuous id_ready_i=1, throughput SHALL be one instruction per cycle after the initial latency.
REQ-026 Under id_ready_i=0, the unit SHALL fill both entries, then hold imem_req_o=0 and the PC until a transfer frees a slot.

Reset
REQ-027 While rst_i=1, the unit SHALL hold:
- PC=RESET_PC;
- queue empty;
- inflight=0 and the kill flag=0;
- imem_req_o=0 and id_valid_o=0;
- id_instr_o=0 and id_pc4_o=0.
REQ-028 The first request SHALL be issued in the first cycle with rst_i=0, at RESET_PC.
REQ-029 Reset asserted mid-operation SHALL discard queued and in-flight instructions; no stale data SHALL appear after reset deasserts.

Structure
REQ-030 Shared package pipe_cpu_pkg SHALL hold:
- XLEN=32;
- the PC increment constant 4;
- the NOP encoding 32'h0000_0000;
- the fetch-entry type {instr, pc4}.
REQ-031 The 2-entry queue SHALL be a sub-module fetch_queue with push, pop, flush, count and head outputs; all other logic SHALL reside in fetch_unit.

Verification
REQ-032 Reset release with RESET_PC=0 and memory word[i]=i -> requests at 0,4,8,... on consecutive cycles; id_valid_o rises 2 cycles later with instr 0/pc4 4, then 1/8, then 2/12.
REQ-033 id_ready_i=0 from cycle 3 for 5 cycles -> queue holds 2 entries and imem_req_o=0; on release, outputs resume with no gap, duplicate or loss.
REQ-034 redirect_i=1 with redirect_pc_i=32'h0000_0103 while 1 entry is queued and 1 is in flight -> next presented instr has pc4=32'h0000_0104; the discarded words are never presented.
REQ-035 Redirect asserted in the same cycle as a transfer -> the transferred instruction counts as flushed; the next id_valid_o is the redirect-target instruction.
REQ-036 redirect_pc_i=32'hFFFF_FFFC -> fetches at FFFF_FFFC then 0000_0000; the presented pc4 values are 0000_0000 and 0000_0004.
REQ-037 rst_i pulsed for 1 cycle with the queue full -> id_valid_o=0 the next cycle; fetch restarts at RESET_PC.
